ram_kbd_mailbox: RTL
====================

// Module: ram_kbd_mailbox
// PURPOSE
//  Parametrised 32-bit data RAM for the MIPS core with a memory-mapped keyboard mailbox.
//  The scan-code interface pushes ASCII codes into a DEPTH-entry FIFO. The CPU pops them
//  through a data port, so keystrokes arriving faster than software polls are kept.
//  The block sits between the CPU data bus and the keyboard scanner, in place of the plain RAM.
// PARAMETERS
//  ADDR_W      13       byte-address width; the RAM holds 2**(ADDR_W-2) words
//  KEY_W       8        width of one key code in the FIFO
//  FIFO_DEPTH  8        mailbox entries; power of 2, at least 2
//  SCAN_ADDR   13'h0310 byte address of the mailbox data port
//  STAT_ADDR   13'h0314 byte address of the mailbox status port
// PORTS
//  clk              in   1       clock; all state updates on the rising edge
//  reset            in   1       synchronous reset, active high
//  ram_addr         in   ADDR_W  CPU byte address; bits [1:0] are ignored
//  ram_read_enable  in   1       CPU load strobe; qualifies the mailbox pop
//  ram_write_enable in   1       CPU store strobe
//  ram_byte_en      in   4       byte-lane enables for stores; bit0 = [7:0]
//  ram_write_data   in   32      CPU store data
//  ram_read_data    out  32      CPU load data; combinational
//  key_ram_addr     in   ADDR_W  scanner target address
//  key_ram_wdata    in   32      scanner data; only [KEY_W-1:0] is used
//  key_ram_wen      in   1       scanner write strobe
//  key_fifo_full    out  1       registered; high when the FIFO holds FIFO_DEPTH entries
// BEHAVIOUR
//  Reset
//   - FIFO pointers and count go to 0; the overflow flag goes to 0; key_fifo_full goes to 0.
//   - RAM contents are not reset.
//  RAM (address is neither SCAN_ADDR nor STAT_ADDR)
//   - Store on the edge: each word lane whose ram_byte_en bit is 1 is written. 4'b0000 is a no-op.
//   - Load is combinational: ram_read_data = mem[ram_addr[ADDR_W-1:2]].
//   - While ram_write_enable=1, ram_read_data is forwarded from ram_write_data instead.
//  Push
//   - Condition: key_ram_wen=1 and key_ram_addr==SCAN_ADDR.
//   - The FIFO is written with key_ram_wdata[KEY_W-1:0].
//   - If the FIFO is full and no pop occurs in the same cycle, the code is dropped and ovf is set (sticky).
//   - Scanner writes to any other address are ignored.
//  Pop
//   - Condition: ram_read_enable=1, ram_write_enable=0, ram_addr==SCAN_ADDR and the FIFO is not empty.
//   - The head is removed on the edge.
//   - Load data for this read = {1'b1 (valid), zeros, head[KEY_W-1:0]}.
//   - If the FIFO is empty, the load returns 32'h0 and there is no pop.
//   - With ram_read_enable=0, the address reads the same data but does not pop.
//  Status read (ram_addr==STAT_ADDR)
//   - Returns {ovf at bit 31, zeros, count at bits [7:0]}.
//   - count ranges 0..FIFO_DEPTH and is sized to hold FIFO_DEPTH.
//  Control writes
//   - CPU store to SCAN_ADDR flushes the FIFO: count and pointers go to 0.
//   - CPU store to STAT_ADDR clears ovf.
//   - Neither store modifies RAM. The byte enables are ignored for these addresses.
//  Simultaneous events
//   - Push and pop in the same cycle, FIFO not empty: both take effect and count is unchanged.
//   - This holds when the FIFO is full: the pop frees a slot, so there is no drop and no ovf.
//   - Push and pop in the same cycle, FIFO empty: only the push occurs, and the load returns 32'h0.
//   - Flush and push in the same cycle: the flush wins, then the pushed code is written.
//     Count ends at 1 and the pointers reset first.
//   - Store to STAT_ADDR in the same cycle as an overflowing push: ovf ends at 1 (the set wins).
//  Pointer rule
//   - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//   - Full and empty are decided from count, not from pointer equality.
//  key_fifo_full = (count==FIFO_DEPTH), registered, so it updates one cycle after the change in count.
//  Reset in the middle of traffic: a push or pop in the reset cycle is discarded.
// TESTING
//  1 Byte enables: after reset, store 32'hAABBCCDD to 0x0040 with byte_en 4'b1111, then
//    store 32'h11223344 with byte_en 4'b0101. A load from 0x0040 returns 32'hAA22CC44.
//  2 Ordering: push 'h41, 'h42, 'h43. Three popping loads of SCAN_ADDR return 32'h80000041,
//    32'h80000042 and 32'h80000043. A fourth load returns 32'h0. Status reads 32'h00000000.
//  3 Overflow: push 9 codes with FIFO_DEPTH=8. key_fifo_full=1 and status reads 32'h80000008.
//    Eight pops return codes 1..8 and code 9 is lost. A store to STAT_ADDR makes status 32'h0.
//  4 Full FIFO with simultaneous push and pop: count stays 8, ovf stays 0, and order is kept
//    across the pointer wrap (write 8 + 4, read 12).
//  5 Flush and reset: push 3 codes, store to SCAN_ADDR, and status reads 32'h0. Push 2 codes,
//    assert reset for one cycle with a push pending, and status reads 32'h0. RAM data written
//    before the reset is still readable.

Source files
------------

// File: rtl/ram_kbd_mailbox.sv
// ram_kbd_mailbox
//   Word-organised 32-bit data RAM for the MIPS core, with a keyboard mailbox
//   mapped into two of its addresses. The keyboard scanner pushes key codes
//   into a small FIFO. The CPU pops them through the data port, so keystrokes
//   that arrive faster than software polls are not lost.
//
// Ports
//   clk              clock, all state changes on the rising edge
//   reset            synchronous reset, active high
//   ram_addr         CPU byte address (bits [1:0] ignored)
//   ram_read_enable  CPU load strobe, qualifies a mailbox pop
//   ram_write_enable CPU store strobe
//   ram_byte_en      store byte-lane enables, bit0 = data[7:0]
//   ram_write_data   CPU store data
//   ram_read_data    CPU load data (combinational)
//   key_ram_addr     scanner target byte address
//   key_ram_wdata    scanner data, only the low KEY_W bits are used
//   key_ram_wen      scanner write strobe
//   key_fifo_full    registered copy of (count == FIFO_DEPTH)
module ram_kbd_mailbox #(
  parameter int                 ADDR_W     = 13,
  parameter int                 KEY_W      = 8,
  parameter int                 FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  SCAN_ADDR  = ADDR_W'(13'h0310),
  parameter logic [ADDR_W-1:0]  STAT_ADDR  = ADDR_W'(13'h0314)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_read_enable,
  input  logic              ram_write_enable,
  input  logic [3:0]        ram_byte_en,
  input  logic [31:0]       ram_write_data,
  output logic [31:0]       ram_read_data,
  input  logic [ADDR_W-1:0] key_ram_addr,
  input  logic [31:0]       key_ram_wdata,
  input  logic              key_ram_wen,
  output logic              key_fifo_full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WORDS = 2 ** (ADDR_W - 2);

  localparam logic [ADDR_W-3:0] SCAN_WORD = SCAN_ADDR[ADDR_W-1:2];
  localparam logic [ADDR_W-3:0] STAT_WORD = STAT_ADDR[ADDR_W-1:2];
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  logic [31:0]       mem [WORDS];
  logic [KEY_W-1:0]  fifo [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf;

  logic [ADDR_W-3:0] cpu_word;
  logic              cpu_is_scan;
  logic              cpu_is_stat;
  logic              cpu_is_ram;
  logic              fifo_empty;
  logic              fifo_is_full;
  logic              push_req;
  logic              pop;
  logic              do_push;
  logic              drop;
  logic              flush;
  logic              clr_ovf;
  logic [KEY_W-1:0]  head;

  // Address bits below word granularity and the unused high scanner data
  // bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{ram_addr[1:0], key_ram_addr[1:0], key_ram_wdata[31:KEY_W]};

  assign cpu_word     = ram_addr[ADDR_W-1:2];
  assign cpu_is_scan  = (cpu_word == SCAN_WORD);
  assign cpu_is_stat  = (cpu_word == STAT_WORD);
  assign cpu_is_ram   = !cpu_is_scan && !cpu_is_stat;

  // Full/empty come from the count so a wrapped pointer pair is never ambiguous.
  assign fifo_empty   = (count == '0);
  assign fifo_is_full = (count == CNT_FULL);
  assign head         = fifo[rd_ptr];

  assign push_req = key_ram_wen && (key_ram_addr[ADDR_W-1:2] == SCAN_WORD);
  assign pop      = ram_read_enable && !ram_write_enable && cpu_is_scan && !fifo_empty;
  assign flush    = ram_write_enable && cpu_is_scan;
  assign clr_ovf  = ram_write_enable && cpu_is_stat;

  // A pop in the same cycle frees the slot, so a push into a full FIFO only
  // drops when nothing is leaving.
  assign do_push  = push_req && (!fifo_is_full || pop);
  assign drop     = push_req && fifo_is_full && !pop;

  // Load path: mailbox ports first, then store-forwarding, then the array.
  always_comb begin
    ram_read_data = 32'h0;
    if (cpu_is_scan) begin
      if (!fifo_empty)
        ram_read_data = {1'b1, {(31-KEY_W){1'b0}}, head};
    end else if (cpu_is_stat) begin
      ram_read_data = {ovf, 23'b0, 8'(count)};
    end else if (ram_write_enable) begin
      ram_read_data = ram_write_data;
    end else begin
      ram_read_data = mem[cpu_word];
    end
  end

  // RAM array is never reset; mailbox addresses never touch it.
  always_ff @(posedge clk) begin
    if (ram_write_enable && cpu_is_ram) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (ram_byte_en[lane])
          mem[cpu_word][lane*8 +: 8] <= ram_write_data[lane*8 +: 8];
      end
    end
  end

  // FIFO storage. A flush rewinds the write pointer, so a code pushed in the
  // flush cycle lands in slot 0.
  always_ff @(posedge clk) begin
    if (!reset && push_req) begin
      if (flush)
        fifo[0] <= key_ram_wdata[KEY_W-1:0];
      else if (do_push)
        fifo[wr_ptr] <= key_ram_wdata[KEY_W-1:0];
    end
  end

  // FIFO control, overflow flag and the lagging full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      key_fifo_full <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        if (push_req) begin
          wr_ptr <= PTR_W'(1);
          count  <= CNT_W'(1);
        end else begin
          wr_ptr <= '0;
          count  <= '0;
        end
      end else begin
        if (do_push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        if (do_push && !pop)
          count <= count + CNT_W'(1);
        else if (pop && !do_push)
          count <= count - CNT_W'(1);
      end

      // An overflowing push beats a clear in the same cycle.
      if (drop)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;

      key_fifo_full <= fifo_is_full;
    end
  end

endmodule
